// File: rtl/input_hub.sv
// input_hub: gathers DS2 pad button state, remaps it to the 8-bit per-player
// layout, derives per-frame edges and a connection bitmap, and bursts them
// into data memory on each copy_start. Also raises a reset request when start
// is held for RESET_HOLD_FRAMES consecutive frames.

// Per-player sampling, snapshot and start-hold tracking.
module input_hub_pad #(
  parameter int RESET_HOLD_FRAMES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [15:0] raw,
  input  logic       valid,
  input  logic       take,
  output logic [7:0] snap_next,
  output logic [7:0] snap,
  output logic [7:0] pressed,
  output logic [7:0] released,
  output logic       conn,
  output logic       hold_hit
);
  localparam logic [3:0] HOLD_MAX = 4'(RESET_HOLD_FRAMES);

  logic [7:0] cur, remap;
  logic       start_cur, seen;
  logic [3:0] hold, hold_next;
  logic       unused_raw;

  // Active-high console layout: {circle,triangle,cross,square,R,L,D,U}.
  assign remap      = ~{raw[2], raw[3], raw[1], raw[0], raw[10], raw[8], raw[9], raw[11]};
  assign unused_raw = ^{raw[15:13], raw[7:4]};

  // A pad that never reported this frame reads as fully released.
  assign snap_next = seen ? cur : 8'h00;
  assign hold_next = !(seen && start_cur) ? 4'd0 :
                     (hold == HOLD_MAX)   ? hold : hold + 4'd1;
  assign hold_hit  = take && (hold_next == HOLD_MAX) && (hold != HOLD_MAX);

  // Sampling: a fresh sample wins over the frame-boundary clear of seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur       <= '0;
      start_cur <= 1'b0;
      seen      <= 1'b0;
    end else begin
      if (valid) begin
        cur       <= remap;
        start_cur <= ~raw[12];
      end
      if (valid)     seen <= 1'b1;
      else if (take) seen <= 1'b0;
    end
  end

  // Snapshot: snap doubles as the previous frame's state for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap     <= '0;
      pressed  <= '0;
      released <= '0;
      conn     <= 1'b0;
      hold     <= '0;
    end else if (take) begin
      snap     <= snap_next;
      pressed  <= snap_next & ~snap;
      released <= ~snap_next & snap;
      conn     <= seen;
      hold     <= hold_next;
    end
  end
endmodule

module input_hub #(
  parameter int PLAYER_COUNT      = 2,
  parameter int DATA_ADDR_WIDTH   = 13,
  parameter int BUTTON_ADDR       = 0,
  parameter int RESET_HOLD_FRAMES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       copy_start,
  input  logic [16*PLAYER_COUNT-1:0] pad_buttons,
  input  logic [PLAYER_COUNT-1:0]    pad_valid,
  output logic                       mem_dout_we,
  output logic [DATA_ADDR_WIDTH-1:0] mem_dout_addr,
  output logic [15:0]                mem_dout,
  output logic                       busy,
  output logic                       reset_req
);
  localparam int NWORDS = 3*PLAYER_COUNT + 1;
  localparam int IW     = $clog2(NWORDS + 1);
  localparam logic [IW-1:0]              LAST = IW'(NWORDS - 1);
  localparam logic [DATA_ADDR_WIDTH-1:0] BASE = DATA_ADDR_WIDTH'(BUTTON_ADDR);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t state, state_n;
  logic [IW-1:0] idx, idx_n, nidx;
  logic          accept;

  logic [PLAYER_COUNT-1:0][15:0] raw_w;
  logic [PLAYER_COUNT-1:0][7:0]  snap_nx, snap, pressed, released;
  logic [PLAYER_COUNT-1:0]       conn, hold_hit;
  logic                          unused_snap;
  logic [15:0]                   word_sel;

  logic                       we_n, rr_n;
  logic [DATA_ADDR_WIDTH-1:0] addr_n;
  logic [15:0]                dout_n;

  assign raw_w       = pad_buttons;
  assign accept      = (state == S_IDLE) && copy_start;
  assign nidx        = idx + 1'b1;
  assign unused_snap = ^snap_nx;

  for (genvar p = 0; p < PLAYER_COUNT; p++) begin : g_pad
    input_hub_pad #(.RESET_HOLD_FRAMES(RESET_HOLD_FRAMES)) u_pad (
      .clk       (clk),
      .reset     (reset),
      .raw       (raw_w[p]),
      .valid     (pad_valid[p]),
      .take      (accept),
      .snap_next (snap_nx[p]),
      .snap      (snap[p]),
      .pressed   (pressed[p]),
      .released  (released[p]),
      .conn      (conn[p]),
      .hold_hit  (hold_hit[p])
    );
  end

  // Word to present next cycle: three words per player, then the bitmap.
  always_comb begin
    word_sel = '0;
    for (int p = 0; p < PLAYER_COUNT; p++) begin
      if (nidx == IW'(3*p))     word_sel = {8'h00, snap[p]};
      if (nidx == IW'(3*p + 1)) word_sel = {8'h00, pressed[p]};
      if (nidx == IW'(3*p + 2)) word_sel = {8'h00, released[p]};
    end
    if (nidx == IW'(3*PLAYER_COUNT)) word_sel = 16'(conn);
  end

  // State register: idx tracks the word currently on the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // Next state: copy_start is only honoured while idle.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      S_IDLE:  if (copy_start) begin state_n = S_WRITE; idx_n = '0; end
      S_WRITE: if (idx == LAST) state_n = S_IDLE;
               else             idx_n   = nidx;
      default: state_n = S_IDLE;
    endcase
  end

  // Output next-values: word 0 comes straight from the pads' snapshot inputs.
  always_comb begin
    we_n   = 1'b0;
    rr_n   = 1'b0;
    addr_n = mem_dout_addr;
    dout_n = mem_dout;
    case (state)
      S_IDLE: if (copy_start) begin
        we_n   = 1'b1;
        addr_n = BASE;
        dout_n = {8'h00, snap_nx[0]};
        rr_n   = |hold_hit;
      end
      S_WRITE: if (idx != LAST) begin
        we_n   = 1'b1;
        addr_n = BASE + DATA_ADDR_WIDTH'(nidx);
        dout_n = word_sel;
      end
      default: ;
    endcase
  end

  // Registered memory port and reset pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_dout_we   <= 1'b0;
      mem_dout_addr <= '0;
      mem_dout      <= '0;
      reset_req     <= 1'b0;
    end else begin
      mem_dout_we   <= we_n;
      mem_dout_addr <= addr_n;
      mem_dout      <= dout_n;
      reset_req     <= rr_n;
    end
  end

  assign busy = mem_dout_we;
endmodule

// File: doc/input_hub.md
# input_hub

Parametrised successor to the fixed two-pad button path in the console top. It collects button state from PLAYER_COUNT DualShock 2 SPI masters, remaps it to the console's 8-bit per-player layout, and derives per-frame pressed/released edges and a connection bitmap. At each `copy_start` it bursts all of these into data memory. It also produces a debounced reset request from the start button held across several frames, replacing the combinational start-button reset term.

## Interface
Parameters:
- PLAYER_COUNT, 2: number of pads, 1..8.
- DATA_ADDR_WIDTH, 13: data memory address width.
- BUTTON_ADDR, 0: base address of the write window.
- RESET_HOLD_FRAMES, 4: consecutive frames start must be held to request reset, 1..15.

Ports (clock and reset first):
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- copy_start  in  1  one-cycle frame tick from the main controller.
- pad_buttons  in  16*PLAYER_COUNT  raw DS2 rx_buffer, active-low. Player p occupies bits [16p+15:16p].
- pad_valid  in  PLAYER_COUNT  one-cycle strobe per pad when its rx_buffer is fresh.
- mem_dout_we  out  1  data memory write enable.
- mem_dout_addr  out  DATA_ADDR_WIDTH  write address.
- mem_dout  out  16  write data.
- busy  out  1  burst in progress.
- reset_req  out  1  one-cycle reset request pulse.

## Operation
- Remap for player p (active-high, bit := ~raw):
  - bit0 = U (raw 11), bit1 = D (9), bit2 = L (8), bit3 = R (10).
  - bit4 = square (0), bit5 = cross (1), bit6 = triangle (3), bit7 = circle (2).
  - start is raw bit 12, used only for reset.
- Sampling, per player:
  - When pad_valid[p] is 1, cur[p] and start_cur[p] load the remapped value and seen[p] sets.
  - When pad_valid[p] is 0, all three hold.
- Snapshot, on a copy_start accepted in IDLE, per player:
  - snap[p] = seen[p] ? cur[p] : 0. A pad silent for a full frame reads as all released.
  - pressed[p] = snap & ~prev; released[p] = ~snap & prev; prev <= snap.
  - conn[p] = seen[p]; seen[p] then clears.
- Reset hold counter per player:
  - If conn[p] and start_cur[p], hold[p] increments, saturating at RESET_HOLD_FRAMES. Otherwise hold[p] clears to 0.
  - reset_req pulses for one cycle when any hold[p] transitions to RESET_HOLD_FRAMES.
  - There is no re-pulse until that counter clears.
- FSM states:
  - IDLE: waits for copy_start. On copy_start, takes the snapshot and goes to WRITE with idx = 0.
  - WRITE: drives one word per cycle. idx increments each cycle; after idx = 3*PLAYER_COUNT it returns to IDLE.
- Word map:
  - Address BUTTON_ADDR+3p holds snap[p], +3p+1 holds pressed[p], +3p+2 holds released[p].
  - Address BUTTON_ADDR+3*PLAYER_COUNT holds the conn bitmap (bit p = player p).
  - All data is zero-extended to 16 bits.
  - Address = BUTTON_ADDR + idx, modulo 2^DATA_ADDR_WIDTH (wraps silently).
- Total burst length N = 3*PLAYER_COUNT+1 words.

## Timing
- Reset values: all outputs 0. cur, prev, seen, hold and the snapshot registers are 0; FSM in IDLE.
- copy_start is sampled on cycle 0. Word k appears with mem_dout_we=1 on cycle 1+k, for k = 0..N-1.
- busy equals mem_dout_we; the cycle after the last word is idle.
- reset_req asserts on cycle 1, coincident with word 0.
- Outputs are registered; address and data change only together with we.
- copy_start while busy is ignored: no snapshot, no restart, edges not consumed.
- pad_valid[p] on the same cycle as an accepted copy_start:
  - the snapshot uses the pre-update cur and seen;
  - the new sample loads cur and sets seen for the next frame, because sampling wins over the clear.
- pad_valid during a burst updates cur only; burst data is from the snapshot.
- Asserting reset mid-burst drops we, busy and reset_req immediately (asynchronously). The partial burst is not resumed.

## Test plan
- Reset, then P=2, BUTTON_ADDR=0x100. Pad0 raw 0xF7FF (U held), valid each frame; pad1 never valid. At copy_start, require 7 writes on cycles 1..7:
  - 0x100=0x0001, 0x101=0x0001, 0x102=0x0000;
  - 0x103..0x105=0;
  - 0x106=0x0001 (conn bitmap).
- Next frame, pad0 raw 0xFFFF → 0x100=0, 0x101=0, 0x102=0x0001.
- Pad0 start held (raw 0xEFFF) for 4 frames with RESET_HOLD_FRAMES=4:
  - reset_req pulses exactly once, on cycle 1 of the 4th burst;
  - it stays 0 on the 5th frame while start is still held;
  - after release and 4 more held frames it pulses again.
- copy_start re-asserted on cycle 3 of a burst → burst is still exactly 7 words, no restart; the following frame's pressed/released are computed against the correct prev.
- pad_valid coincident with copy_start carrying a new value → burst shows the old state; the next burst shows the new state with the matching pressed bit.
- BUTTON_ADDR=2^13-2 with P=1 → addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001. Asserting reset on burst cycle 2 → we is 0 immediately and no further writes occur.
